axis_reg_packetizer: RTL
========================

// Module: axis_reg_packetizer
// PURPOSE
//   Upstream feeder for the AXI-Stream-to-SPI serializer. Accepts one sensor
//   register write command (address + data) and emits it as a byte packet,
//   most-significant byte first, with TLAST on the final byte.
//   Optionally waits for the serializer's done pulse, or a timeout, before
//   accepting the next command. Used for camera-sensor config over SPI.
// PARAMETERS
//   ADDR_BYTES    2     register address width in bytes (1..4)
//   DATA_BYTES    1     register data width in bytes (1..4)
//   WAIT_DONE     1     1: wait for spi_done after the last beat; 0: return to IDLE immediately
//   DONE_TIMEOUT  4096  cycles to wait for spi_done before flagging an error (>=2)
// PORTS
//   clk          in   1               system clock; all logic on posedge
//   reset        in   1               synchronous, active-high reset
//   cmd_valid    in   1               command present
//   cmd_ready    out  1               command accepted when cmd_valid && cmd_ready
//   cmd_addr     in   8*ADDR_BYTES    register address
//   cmd_data     in   8*DATA_BYTES    register data
//   TDATA        out  8               stream byte to the SPI serializer
//   TVALID       out  1               stream beat valid
//   TREADY       in   1               serializer ready
//   TLAST        out  1               high on the last byte of the packet
//   spi_done     in   1               serializer end-of-packet pulse
//   busy         out  1               high in every state except IDLE
//   timeout_err  out  1               one-cycle pulse when DONE_TIMEOUT expires
// BEHAVIOUR
//   - Clock and reset: one clock (clk). Reset is synchronous, active-high.
//     When reset is high, all registered outputs are 0 on the next edge
//     (cmd_ready, TDATA, TVALID, TLAST, busy, timeout_err); state goes to IDLE.
//     Reset wins over every other event, including in the middle of a packet.
//     A partial packet is dropped; no further beats follow.
//   - N = ADDR_BYTES + DATA_BYTES.
//   - Shift register holds {cmd_addr, cmd_data}, N*8 bits wide.
//   - Byte counter is $clog2(N+1) bits wide.
//   - All outputs are registered.
//   - States: IDLE, SEND, WAIT.
//   - IDLE:
//       - cmd_ready <= 1.
//       - On cmd_valid && cmd_ready:
//           - capture {addr, data}
//           - cmd_ready <= 0, busy <= 1
//           - TVALID <= 1, TDATA <= top byte
//           - cnt <= N-1, TLAST <= (N==1)
//           - next state SEND
//       - First beat is visible the cycle after acceptance (latency 1).
//   - SEND:
//       - TDATA and TLAST stay stable while TVALID && !TREADY.
//       - On TVALID && TREADY with cnt != 0:
//           - shift left 8 bits; TDATA <= next byte
//           - cnt <= cnt-1, TLAST <= (cnt==1)
//           - no bubble between beats
//       - On TVALID && TREADY with cnt == 0:
//           - TVALID <= 0, TLAST <= 0
//           - WAIT_DONE=1: clear timer, go to WAIT
//           - WAIT_DONE=0: go to IDLE
//   - WAIT:
//       - timer increments each cycle.
//       - spi_done -> IDLE.
//       - Else, when timer == DONE_TIMEOUT-1: timeout_err <= 1 for one cycle,
//         then IDLE.
//       - If spi_done arrives on the expiry cycle, it wins; no error is raised.
//   - spi_done is ignored in IDLE and SEND.
//   - cmd_ready is 0 outside IDLE; a pending cmd_valid is held off and
//     is not lost.
//   - busy = (state != IDLE), registered.
//   - The minimum gap between packets is 1 cycle with cmd_ready high in IDLE
//     (IDLE re-asserts cmd_ready on entry).
// TESTING
//   1. Basic packet. Defaults, addr=0x3012, data=0xA5, TREADY=1.
//      -> Beats 0x30, 0x12, 0xA5 on 3 consecutive cycles; TLAST only on 0xA5.
//      -> spi_done 10 cycles later -> cmd_ready=1 on the next cycle.
//   2. Backpressure. Same command, TREADY high 1 cycle in every 4.
//      -> Same 3 bytes in order; TDATA/TLAST stable during stalls.
//      -> Exactly one TLAST.
//   3. Held-off command. Second command (0x0100/0x7F) valid during SEND/WAIT.
//      -> cmd_ready stays 0.
//      -> Bytes 0x01, 0x00, 0x7F are emitted only after the first packet's spi_done.
//   4. Timeout. DONE_TIMEOUT=16, no spi_done.
//      -> timeout_err is a single pulse 16 cycles after the last handshake.
//      -> Returns to IDLE; cmd_ready=1.
//   5. Reset mid-packet. Assert reset after the 0x30 beat.
//      -> Next cycle all outputs are 0.
//      -> A new command restarts at its first byte.
//   6. Misc. spi_done pulsed in IDLE and SEND -> ignored.
//      WAIT_DONE=0 -> cmd_ready=1 the cycle after the TLAST handshake.

Source files
------------

// File: rtl/axis_reg_packetizer.sv
// Register-write packetizer: turns one {address, data} command into an MSB-first
// AXI-Stream byte packet, then optionally waits for the SPI serializer's done pulse.
module axis_reg_packetizer #(
    parameter int ADDR_BYTES   = 2,
    parameter int DATA_BYTES   = 1,
    parameter int WAIT_DONE    = 1,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [8*ADDR_BYTES-1:0] cmd_addr,
    input  logic [8*DATA_BYTES-1:0] cmd_data,
    output logic [7:0]              TDATA,
    output logic                    TVALID,
    input  logic                    TREADY,
    output logic                    TLAST,
    input  logic                    spi_done,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [1:0]              o_dbg_state
);
    localparam int N  = ADDR_BYTES + DATA_BYTES;
    localparam int W  = 8 * N;
    localparam int CW = $clog2(N + 1);
    localparam int TW = $clog2(DONE_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Handshakes: a command transfers when cmd_valid && cmd_ready; a stream beat
    // transfers when TVALID && TREADY. TDATA/TLAST hold while TVALID && !TREADY.
    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_shift, w_shift_nxt;
    logic [W-1:0]  w_shift_adv;
    logic [W-1:0]  w_cmd_word;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          r_cmd_ready, w_cmd_ready_nxt;
    logic [7:0]    r_tdata, w_tdata_nxt;
    logic          r_tvalid, w_tvalid_nxt;
    logic          r_tlast, w_tlast_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic          w_cmd_hs;
    logic          w_beat_hs;

    assign w_cmd_word  = {cmd_addr, cmd_data};
    assign w_shift_adv = r_shift << 8;
    assign w_cmd_hs    = cmd_valid && r_cmd_ready;
    assign w_beat_hs   = r_tvalid && TREADY;

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_timer_nxt     = r_timer;
        w_cmd_ready_nxt = r_cmd_ready;
        w_tdata_nxt     = r_tdata;
        w_tvalid_nxt    = r_tvalid;
        w_tlast_nxt     = r_tlast;
        w_busy_nxt      = r_busy;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                w_busy_nxt      = 1'b0;
                if (w_cmd_hs) begin
                    w_shift_nxt     = w_cmd_word;
                    w_tdata_nxt     = w_cmd_word[W-1 -: 8];
                    w_tvalid_nxt    = 1'b1;
                    w_tlast_nxt     = (N == 1);
                    w_cnt_nxt       = CNT_LAST;
                    w_cmd_ready_nxt = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = S_SEND;
                end
            end
            S_SEND: begin
                // r_cnt counts the bytes still queued behind the one on TDATA.
                if (w_beat_hs) begin
                    if (r_cnt != '0) begin
                        w_shift_nxt = w_shift_adv;
                        w_tdata_nxt = w_shift_adv[W-1 -: 8];
                        w_cnt_nxt   = r_cnt - 1'b1;
                        w_tlast_nxt = (r_cnt == CW'(1));
                    end else begin
                        w_tvalid_nxt = 1'b0;
                        w_tlast_nxt  = 1'b0;
                        if (WAIT_DONE != 0) begin
                            w_timer_nxt = '0;
                            w_state_nxt = S_WAIT;
                        end else begin
                            w_cmd_ready_nxt = 1'b1;
                            w_busy_nxt      = 1'b0;
                            w_state_nxt     = S_IDLE;
                        end
                    end
                end
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + 1'b1;
                // A done pulse on the expiry cycle takes priority over the error.
                if (spi_done) begin
                    w_cmd_ready_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = S_IDLE;
                end else if (r_timer == TIMER_MAX) begin
                    w_timeout_nxt   = 1'b1;
                    w_cmd_ready_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_cmd_ready <= 1'b0;
            r_tdata     <= 8'h00;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_timer     <= w_timer_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_tdata     <= w_tdata_nxt;
            r_tvalid    <= w_tvalid_nxt;
            r_tlast     <= w_tlast_nxt;
            r_busy      <= w_busy_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign TDATA       = r_tdata;
    assign TVALID      = r_tvalid;
    assign TLAST       = r_tlast;
    assign busy        = r_busy;
    assign timeout_err = r_timeout;
    assign o_dbg_state = r_state;

endmodule
